// File: rtl/str_conv_pkg.sv
// Shared types and ASCII constants for the string<->integer conversion blocks.
package str_conv_pkg;

  typedef enum logic [1:0] {
    RADIX_DEC = 2'd0,
    RADIX_HEX = 2'd1,
    RADIX_OCT = 2'd2,
    RADIX_BIN = 2'd3
  } radix_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] ASC_0     = 8'h30;
  localparam logic [7:0] ASC_9     = 8'h39;
  localparam logic [7:0] ASC_A_LC  = 8'h61;
  localparam logic [7:0] ASC_F_LC  = 8'h66;
  localparam logic [7:0] ASC_A_UC  = 8'h41;
  localparam logic [7:0] ASC_F_UC  = 8'h46;
  localparam logic [7:0] ASC_US    = 8'h5F;
  localparam logic [7:0] ASC_MINUS = 8'h2D;

endpackage

// File: rtl/str_digit_decode.sv
// Classifies one ASCII character as a digit of the given radix and yields its value.
module str_digit_decode
  import str_conv_pkg::*;
(
  input  logic [7:0] ch_data,
  input  logic [1:0] radix,
  output logic       is_digit,
  output logic [3:0] digit
);

  logic is_dec, is_lc, is_uc;

  always_comb begin
    is_dec = (ch_data >= ASC_0)    && (ch_data <= ASC_9);
    is_lc  = (ch_data >= ASC_A_LC) && (ch_data <= ASC_F_LC);
    is_uc  = (ch_data >= ASC_A_UC) && (ch_data <= ASC_F_UC);
    // 'a'/'A' have low nibble 1, so adding 9 maps a..f / A..F onto 10..15
    digit  = is_dec ? ch_data[3:0] : (ch_data[3:0] + 4'd9);
    is_digit = 1'b0;
    case (radix_e'(radix))
      RADIX_DEC: is_digit = is_dec;
      RADIX_HEX: is_digit = is_dec | is_lc | is_uc;
      RADIX_OCT: is_digit = (ch_data >= ASC_0) && (ch_data <= 8'h37);
      RADIX_BIN: is_digit = (ch_data == ASC_0) || (ch_data == 8'h31);
      default:   is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/str_ato_parser.sv
// Streaming atoi/atohex/atooct/atobin: accumulates leading digits of a character
// stream into a WIDTH-bit value and holds the result until it is consumed.
module str_ato_parser
  import str_conv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       radix,
  input  logic             ch_valid,
  input  logic [7:0]       ch_data,
  input  logic             ch_last,
  output logic             ch_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_value,
  output logic             res_ovf,
  output logic [CNT_W-1:0] res_digits
);

  state_e             state_q;
  radix_e             radix_q;
  logic [WIDTH-1:0]   acc_q, acc_d, acc_fin;
  logic               ovf_q, ovf_d, ovf_fin;
  logic               neg_q, neg_d, neg_fin;
  logic               seen_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_fin;
  logic               ch_ready_q, res_valid_q, res_ovf_q;
  logic [WIDTH-1:0]   res_value_q;
  logic [CNT_W-1:0]   res_digits_q;

  logic               is_digit, is_us, is_minus, term, beat, in_scan;
  logic [3:0]         digit;
  logic [WIDTH+3:0]   ext, prod, sum;

  str_digit_decode u_dec (
    .ch_data  (ch_data),
    .radix    (radix_q),
    .is_digit (is_digit),
    .digit    (digit)
  );

  // Four guard bits cover the worst case acc*16+15, so any set guard bit is lost data.
  always_comb begin
    ext = {4'b0, acc_q};
    case (radix_q)
      RADIX_DEC: prod = (ext << 3) + (ext << 1);
      RADIX_HEX: prod = ext << 4;
      RADIX_OCT: prod = ext << 3;
      default:   prod = ext << 1;
    endcase
    sum      = prod + {{WIDTH{1'b0}}, digit};
    is_us    = (ch_data == ASC_US);
    is_minus = (radix_q == RADIX_DEC) && (ch_data == ASC_MINUS) && !seen_q;
    term     = !is_digit && !is_us && !is_minus;
    beat     = ch_valid && ch_ready_q;
    in_scan  = (state_q == SCAN);

    acc_d = is_digit ? sum[WIDTH-1:0] : acc_q;
    ovf_d = ovf_q | (is_digit & (|sum[WIDTH+3:WIDTH]));
    cnt_d = (is_digit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    neg_d = neg_q | is_minus;

    acc_fin = in_scan ? acc_d : acc_q;
    ovf_fin = in_scan ? ovf_d : ovf_q;
    cnt_fin = in_scan ? cnt_d : cnt_q;
    neg_fin = in_scan ? neg_d : neg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      radix_q      <= RADIX_DEC;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      neg_q        <= 1'b0;
      seen_q       <= 1'b0;
      cnt_q        <= '0;
      ch_ready_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_value_q  <= '0;
      res_ovf_q    <= 1'b0;
      res_digits_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          radix_q    <= radix_e'(radix);
          acc_q      <= '0;
          ovf_q      <= 1'b0;
          neg_q      <= 1'b0;
          seen_q     <= 1'b0;
          cnt_q      <= '0;
          ch_ready_q <= 1'b1;
          state_q    <= SCAN;
        end
        SCAN: if (beat) begin
          acc_q  <= acc_d;
          ovf_q  <= ovf_d;
          cnt_q  <= cnt_d;
          neg_q  <= neg_d;
          seen_q <= seen_q | is_digit | is_us;
          if (!ch_last && term) state_q <= DRAIN;
        end
        DRAIN: ;
        DONE: if (res_ready) begin
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // The ch_last beat closes the string from either SCAN or DRAIN.
      if (beat && ch_last && (state_q == SCAN || state_q == DRAIN)) begin
        state_q      <= DONE;
        ch_ready_q   <= 1'b0;
        res_valid_q  <= 1'b1;
        res_value_q  <= neg_fin ? -acc_fin : acc_fin;
        res_ovf_q    <= ovf_fin;
        res_digits_q <= cnt_fin;
      end
    end
  end

  assign ch_ready   = ch_ready_q;
  assign res_valid  = res_valid_q;
  assign res_value  = res_value_q;
  assign res_ovf    = res_ovf_q;
  assign res_digits = res_digits_q;

endmodule

// File: tb/tb_str_ato_parser.sv
// Directed bench for str_ato_parser; a WIDTH=8 copy shares the stimulus for wrap cases.
module tb_str_ato_parser;

  logic        clk = 1'b0;
  logic        rst_n, start, ch_valid, ch_last, res_ready;
  logic [1:0]  radix;
  logic [7:0]  ch_data;
  logic        ch_ready, res_valid, res_ovf;
  logic [31:0] res_value;
  logic [7:0]  res_digits;
  logic        ch_ready8, res_valid8, res_ovf8;
  logic [7:0]  res_value8;
  logic [7:0]  res_digits8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  str_ato_parser #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .radix(radix),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_ovf(res_ovf), .res_digits(res_digits)
  );

  str_ato_parser #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .radix(radix),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_last(ch_last), .ch_ready(ch_ready8),
    .res_valid(res_valid8), .res_ready(res_ready), .res_value(res_value8),
    .res_ovf(res_ovf8), .res_digits(res_digits8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic begin_conv(input logic [1:0] r);
    start = 1'b1;
    radix = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    chk("ch_ready", ch_ready, 1);
    ch_valid = 1'b1;
    ch_data  = d;
    ch_last  = last;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_last  = 1'b0;
  endtask

  task automatic conv(input string tag, input logic [1:0] r, input string s,
                      input logic [31:0] ev, input logic [7:0] ed, input logic eo);
    begin_conv(r);
    for (int i = 0; i < s.len(); i++) send_beat(s[i], i == s.len() - 1);
    chk({tag, ".valid"}, res_valid, 1);
    chk({tag, ".value"}, res_value, ev);
    chk({tag, ".digits"}, res_digits, ed);
    chk({tag, ".ovf"}, res_ovf, eo);
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; radix = 2'd0; ch_valid = 1'b0;
    ch_data = 8'h0; ch_last = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("rst.ch_ready", ch_ready, 0);
    chk("rst.res_valid", res_valid, 0);
    chk("rst.res_value", res_value, 0);
    chk("rst.res_ovf", res_ovf, 0);
    chk("rst.res_digits", res_digits, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.ch_ready", ch_ready, 0);

    conv("dec101", 2'd0, "101", 32'd101, 8'd3, 1'b0); ack();
    conv("hex101", 2'd1, "101", 32'h101, 8'd3, 1'b0); ack();
    conv("oct101", 2'd2, "101", 32'd65,  8'd3, 1'b0); ack();
    conv("bin101", 2'd3, "101", 32'd5,   8'd3, 1'b0); ack();
    chk("idle_keep.value", res_value, 32'd5);
    chk("idle_keep.valid", res_valid, 0);

    // 'x' sends the parser to DRAIN; send_beat checks ch_ready stays high for '9'
    conv("drain", 2'd0, "1_2x9", 32'd12, 8'd2, 1'b0); ack();
    conv("hexUC", 2'd1, "7B", 32'd123, 8'd2, 1'b0); ack();
    conv("hexLC", 2'd1, "7b", 32'd123, 8'd2, 1'b0); ack();
    conv("oct78", 2'd2, "78", 32'd7, 8'd1, 1'b0); ack();
    conv("bin1021", 2'd3, "1021", 32'd2, 8'd2, 1'b0); ack();

    conv("dec300", 2'd0, "300", 32'd300, 8'd3, 1'b0);
    chk("w8_300.value", res_value8, 8'd44);
    chk("w8_300.ovf", res_ovf8, 1);
    ack();
    conv("dec255", 2'd0, "255", 32'd255, 8'd3, 1'b0);
    chk("w8_255.value", res_value8, 8'd255);
    chk("w8_255.ovf", res_ovf8, 0);
    ack();

    conv("hexneg", 2'd1, "-1", 32'd0, 8'd0, 1'b0); ack();
    begin_conv(2'd0);
    send_beat(8'h00, 1'b1);
    chk("empty.valid", res_valid, 1);
    chk("empty.value", res_value, 0);
    chk("empty.digits", res_digits, 0);
    ack();
    conv("minus_only", 2'd0, "-", 32'd0, 8'd0, 1'b0); ack();

    // Result held with res_ready low; start must not disturb it.
    conv("dec-42", 2'd0, "-42", 32'hFFFF_FFD6, 8'd2, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold.valid", res_valid, 1);
      chk("hold.value", res_value, 32'hFFFF_FFD6);
      chk("hold.ch_ready", ch_ready, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_ack.valid", res_valid, 0);
    chk("post_ack.ch_ready", ch_ready, 0);
    chk("post_ack.value", res_value, 32'hFFFF_FFD6);

    begin_conv(2'd0);
    send_beat("1", 1'b0);
    send_beat("2", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort.ch_ready", ch_ready, 0);
    chk("abort.valid", res_valid, 0);
    chk("abort.value", res_value, 0);
    chk("abort.digits", res_digits, 0);
    chk("abort.ovf", res_ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    conv("after_rst", 2'd0, "9", 32'd9, 8'd1, 1'b0); ack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/str_ato_parser.md
Name: str_ato_parser

Overview:
Streaming hardware equivalent of the string atoi/atohex/atooct/atobin methods. It accepts an ASCII character stream over a valid/ready handshake and accumulates the leading digits in the selected radix into a WIDTH-bit integer. It presents the result on a held valid/ready output port. It sits downstream of any byte or string source, as the receiving end of a formatter (itoa-style) stream.

Parameters:
WIDTH, 32, result width in bits (2..64)
CNT_W, 8, width of digit counter (saturating)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin conversion; sampled only in IDLE
radix  input  2  sampled with start: 0=dec, 1=hex, 2=oct, 3=bin
ch_valid  input  1  character beat valid
ch_data  input  8  ASCII character
ch_last  input  1  final character of string
ch_ready  output  1  character beat accepted when ch_valid&&ch_ready
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid&&res_ready
res_value  output  WIDTH  converted value
res_ovf  output  1  sticky: significant bits were lost (wrap)
res_digits  output  CNT_W  digits consumed (saturating at all-ones)

Behaviour:
- Reset is asynchronous and active-low; one clock `clk`. During and after reset: state=IDLE, ch_ready=0, res_valid=0, res_value=0, res_ovf=0, res_digits=0.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: ch_ready=0. start=1 latches radix, clears acc/ovf/count/neg, goes to SCAN next cycle. Character beats are not accepted.
- SCAN: ch_ready=1. For each accepted beat:
  - Digit valid for radix (dec 0-9; hex 0-9/a-f/A-F; oct 0-7; bin 0-1): acc = acc*radix + d, truncated to WIDTH bits. ovf |= any discarded bit of the full product+sum. count += 1, saturating.
  - '_' (0x5F): ignored, stays in SCAN.
  - '-' (0x2D): only in decimal and only before any digit or '_' has been accepted; sets neg.
  - Any other character, including NUL, '8' in octal, or '2' in binary: terminates scanning.
- Transitions from SCAN on an accepted beat: ch_last=1 goes to DONE, whether the character was a digit or not. A terminating non-digit with ch_last=0 goes to DRAIN.
- DRAIN: ch_ready=1. Beats are consumed and discarded; an accepted beat with ch_last=1 goes to DONE.
- DONE: res_valid=1. res_value = neg ? -acc (two's complement, WIDTH bits) : acc. res_ovf and res_digits reflect the scan.
  - Outputs are held stable until res_ready=1, then the block returns to IDLE.
  - A start in the handshake cycle is ignored.
- Latency: res_valid asserts the cycle after the ch_last beat is accepted.
- Empty string: a single NUL beat with ch_last gives res_value=0, res_digits=0.
- A '-' with no digits gives 0.
- res_value, res_ovf and res_digits are registered and keep the last result in IDLE until the next conversion completes.
- start while not in IDLE is ignored.
- rst_n low mid-conversion aborts immediately to IDLE with all outputs cleared; no partial result is emitted.
- Multiply by 2/8/16 is a shift and by 10 is (acc<<3)+(acc<<1). The block uses no divider.

Decomposition:
- Package str_conv_pkg:
  - radix_e enum (RADIX_DEC, RADIX_HEX, RADIX_OCT, RADIX_BIN)
  - state_e enum (IDLE, SCAN, DRAIN, DONE)
  - ASCII constants (ASC_0, ASC_9, ASC_A_LC, ASC_F_LC, ASC_A_UC, ASC_F_UC, ASC_US, ASC_MINUS)
- One combinational sub-module, str_digit_decode: inputs ch_data and radix; outputs is_digit and 4-bit digit value. It is shared with the future itoa-side formatter's checker.

Test Plan:
- Radix check on "101"+last: dec -> 101, hex -> 'h101, oct -> 'o101 (65), bin -> 'b101 (5). res_digits=3 and res_ovf=0 in every case.
- Terminator and underscore, dec "1_2x9" (last on '9'): 'x' moves to DRAIN, '9' is discarded. Result 12, digits=2, and ch_ready stays 1 through DRAIN.
- Hex case mix "7B" -> 123 and "7b" -> 123. Octal "78" -> 7, digits=1. Binary "1021" -> 2.
- Overflow with WIDTH=8: dec "300" -> res_value=44, res_ovf=1. Dec "255" -> 255, ovf=0.
- Sign: dec "-42" -> 'hFFFFFFD6. Hex "-1" -> 0, digits=0 ('-' terminates in hex). Empty NUL beat -> 0.
- Handshake and reset:
  - Hold res_ready=0 for 5 cycles: res_valid and res_value stay stable, ch_ready=0, and start is ignored.
  - Assert rst_n=0 mid-SCAN after "12": all outputs go to 0 immediately. A fresh start then "9"+last gives 9.
